// File: rtl/synth_pkg.sv
// Shared types, key increment table and waveform shaper for the polyphonic voice engine.
// Pure declarations; no state.
package synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW     = 2'd0,
      WAVE_SQUARE  = 2'd1,
      WAVE_TRI     = 2'd2,
      WAVE_INV_SAW = 2'd3
   } wave_t;

   localparam int KEY_INC_W = 16;

   // Equal-tempered semitone steps from 0x0400 up to one octave (0x0800).
   localparam logic [KEY_INC_W-1:0] KEY_INC [0:12] = '{
      16'h0400, 16'h043D, 16'h047D, 16'h04C2, 16'h050A, 16'h0557, 16'h05A8,
      16'h05FE, 16'h0659, 16'h06BA, 16'h0721, 16'h078D, 16'h0800
   };

   function automatic logic [KEY_INC_W-1:0] key_inc(input int unsigned idx);
      key_inc = (idx < 32'd13) ? KEY_INC[idx[3:0]] : '0;
   endfunction

   // Width-generic shaper: p holds a w-bit sample in its low bits.
   function automatic logic [31:0] shape(input logic [31:0] p, input wave_t wave, input int unsigned w);
      logic [31:0] mask;
      logic [31:0] dbl;
      logic        msb;
      mask = (32'd1 << w) - 32'd1;
      dbl  = p << 1;
      msb  = ((p >> (w - 32'd1)) & 32'd1) != 32'd0;
      case (wave)
         WAVE_SAW:     shape = p & mask;
         WAVE_SQUARE:  shape = msb ? mask : 32'd0;
         WAVE_TRI:     shape = msb ? (~dbl & mask) : (dbl & mask);
         default:      shape = ~p & mask;
      endcase
   endfunction

endpackage

// File: rtl/voice_allocator.sv
// Key edge detection, pending queue and oldest-steal voice assignment; one key per cycle.
// Press reaches o_active two cycles later; a release frees its voice on the next edge.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_KEYS   = 13,
   parameter int NUM_VOICES = 4,
   localparam int KW = $clog2(NUM_KEYS),
   localparam int VW = $clog2(NUM_VOICES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_KEYS-1:0]              i_keys,
   output logic [NUM_VOICES-1:0]            o_active,
   output logic [NUM_VOICES-1:0][KW-1:0]    o_key_idx,
   output logic                             o_alloc,
   output logic [VW-1:0]                    o_alloc_voice,
   output logic [NUM_VOICES-1:0]            o_release,
   output logic                             o_steal
);

   logic [NUM_KEYS-1:0]   r_keys_q, r_pending;
   logic [NUM_VOICES-1:0] r_active;
   logic [KW-1:0]         r_key_idx [NUM_VOICES];
   logic [VW-1:0]         r_age     [NUM_VOICES];

   logic [NUM_KEYS-1:0]   w_press, w_rel, w_cand, w_key_oh;
   logic [NUM_VOICES-1:0] w_rel_v;
   logic [KW-1:0]         w_key;
   logic [VW-1:0]         w_free_v, w_victim, w_victim_age, w_alloc_v;
   logic                  w_any_cand, w_dup, w_any_free, w_alloc, w_steal;

   always_comb begin
      w_press = i_keys & ~r_keys_q;
      w_rel   = ~i_keys & r_keys_q;
      // A key released in the same window it was pressed must never win allocation.
      w_cand  = r_pending & ~w_rel;

      w_key      = '0;
      w_any_cand = 1'b0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (w_cand[k]) begin
            w_key      = KW'(k);
            w_any_cand = 1'b1;
         end
      end
      w_key_oh = w_any_cand ? (NUM_KEYS'(1) << w_key) : '0;

      w_rel_v = '0;
      w_dup   = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         w_rel_v[v] = r_active[v] & w_rel[r_key_idx[v]];
         if (r_active[v] && r_key_idx[v] == w_key) w_dup = 1'b1;
      end

      w_free_v   = '0;
      w_any_free = 1'b0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!r_active[v]) begin
            w_free_v   = VW'(v);
            w_any_free = 1'b1;
         end
      end

      w_victim     = '0;
      w_victim_age = r_age[0];
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (r_age[v] > w_victim_age) begin
            w_victim     = VW'(v);
            w_victim_age = r_age[v];
         end
      end

      w_alloc   = w_any_cand & ~w_dup;
      w_alloc_v = w_any_free ? w_free_v : w_victim;
      w_steal   = w_alloc & ~w_any_free;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_keys_q  <= '0;
         r_pending <= '0;
         r_active  <= '0;
         o_steal   <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_key_idx[v] <= '0;
            r_age[v]     <= '0;
         end
      end else begin
         r_keys_q  <= i_keys;
         r_pending <= (r_pending & ~w_rel & ~w_key_oh) | w_press;
         o_steal   <= w_steal;
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_alloc && w_alloc_v == VW'(v)) begin
               r_active[v]  <= 1'b1;
               r_key_idx[v] <= w_key;
               r_age[v]     <= '0;
            end else if (w_rel_v[v]) begin
               r_active[v] <= 1'b0;
               r_age[v]    <= '0;
            end else if (w_alloc && r_active[v] && r_age[v] != VW'(NUM_VOICES - 1)) begin
               r_age[v] <= r_age[v] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) o_key_idx[v] = r_key_idx[v];
   end

   assign o_active      = r_active;
   assign o_alloc       = w_alloc;
   assign o_alloc_voice = w_alloc_v;
   assign o_release     = w_rel_v;

endmodule

// File: rtl/poly_voice_engine.sv
// Polyphonic tone generator: shared phase-accumulator voices, waveform shaping and a fixed-scale mixer.
// Phase advances on the tick edge; sample_o/sample_valid_o follow one cycle later, once per CLK_DIV clocks.
module poly_voice_engine
   import synth_pkg::*;
#(
   parameter int NUM_KEYS   = 13,
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 8,
   parameter int PHASE_W    = 16,
   parameter int CLK_DIV    = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_KEYS-1:0]   keys_i,
   input  logic [1:0]            octave_i,
   input  logic [1:0]            mode_i,
   output logic [SAMPLE_W-1:0]   sample_o,
   output logic                  sample_valid_o,
   output logic [NUM_VOICES-1:0] voice_active_o,
   output logic                  steal_o
);

   localparam int KW    = $clog2(NUM_KEYS);
   localparam int VW    = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int SUM_W = SAMPLE_W + VW;

   logic [NUM_VOICES-1:0][KW-1:0] w_key_idx;
   logic [NUM_VOICES-1:0]         w_rel_v;
   logic [VW-1:0]                 w_alloc_v;
   logic                          w_alloc, w_tick;

   logic [PHASE_W-1:0]  r_phase [NUM_VOICES];
   logic [PHASE_W-1:0]  w_inc   [NUM_VOICES];
   logic [SAMPLE_W-1:0] w_shp   [NUM_VOICES];
   logic [SUM_W-1:0]    w_sum;
   logic [CNT_W-1:0]    r_tick_cnt;
   logic                r_tick_d;
   wave_t               r_mode;

   voice_allocator #(
      .NUM_KEYS   (NUM_KEYS),
      .NUM_VOICES (NUM_VOICES)
   ) u_alloc (
      .clk           (clk),
      .rst           (rst),
      .i_keys        (keys_i),
      .o_active      (voice_active_o),
      .o_key_idx     (w_key_idx),
      .o_alloc       (w_alloc),
      .o_alloc_voice (w_alloc_v),
      .o_release     (w_rel_v),
      .o_steal       (steal_o)
   );

   assign w_tick = (r_tick_cnt == CNT_W'(CLK_DIV - 1));

   always_comb begin
      w_sum = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         w_inc[v] = PHASE_W'(key_inc(32'(w_key_idx[v])));
         w_shp[v] = '0;
         if (voice_active_o[v])
            w_shp[v] = SAMPLE_W'(shape(32'(r_phase[v][PHASE_W-1 -: SAMPLE_W]), r_mode, 32'(SAMPLE_W)));
         w_sum = w_sum + SUM_W'(w_shp[v]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt     <= '0;
         r_tick_d       <= 1'b0;
         r_mode         <= WAVE_SAW;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= '0;
      end else begin
         r_tick_cnt     <= w_tick ? '0 : r_tick_cnt + 1'b1;
         r_tick_d       <= w_tick;
         sample_valid_o <= r_tick_d;
         if (w_tick) r_mode <= wave_t'(mode_i);
         if (r_tick_d) sample_o <= SAMPLE_W'(w_sum >> VW);
         // A fresh allocation restarts at zero even on a tick; released voices hold their phase.
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_alloc && w_alloc_v == VW'(v))
               r_phase[v] <= '0;
            else if (w_tick && voice_active_o[v] && !w_rel_v[v])
               r_phase[v] <= r_phase[v] + (w_inc[v] >> octave_i);
         end
      end
   end

endmodule

// File: doc/poly_voice_engine.md
# poly_voice_engine

Parametrised polyphonic tone generator: NUM_KEYS key inputs share NUM_VOICES phase-accumulator voices through an oldest-steal allocator. Waveform shaping, octave shift and mixing are built in. It sits between the key/octave/mode front end (encoder and FSMs) and the `pwm` block, and replaces the fixed one-oscillator-per-key arrangement. It emits one mixed sample per sample tick, together with a valid strobe.

## Interface
- NUM_KEYS, 13: number of key inputs.
- NUM_VOICES, 4: simultaneous voices; must be a power of two, at least 2.
- SAMPLE_W, 8: sample width.
- PHASE_W, 16: phase accumulator width.
- CLK_DIV, 256: clocks per sample tick; must be at least 4.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- keys_i  in  NUM_KEYS  level per key; 1 = held.
- octave_i  in  2  octave-down count, 0..3.
- mode_i  in  2  waveform: 0 saw, 1 square, 2 triangle, 3 inverted saw.
- sample_o  out  SAMPLE_W  mixed sample.
- sample_valid_o  out  1  one-cycle strobe when sample_o updates.
- voice_active_o  out  NUM_VOICES  per-voice busy flag.
- steal_o  out  1  one-cycle pulse when an active voice is stolen.

## Operation
- Edge detect:
  - keys_q registers keys_i.
  - Each cycle, presses (keys_i & ~keys_q) are OR-ed into a pending mask.
  - Releases (~keys_i & keys_q) clear the matching pending bits.
- Release: every active voice whose key_idx has a release this cycle goes inactive this cycle. Phase is held; age is cleared.
- Allocation handles at most one key per cycle: the lowest-index pending key, whose pending bit is cleared.
  - If any voice is free (excluding voices freed this cycle), the lowest-index free voice is taken.
  - Otherwise the voice with the highest age is stolen (ties go to the lowest index), and steal_o pulses.
  - The allocated voice gets key_idx = key, phase = 0, age = 0, active = 1.
  - Every other active voice has its age incremented, saturating at NUM_VOICES-1.
- Duplicate guard: a pending key already held by an active voice is dropped without allocating.
- Sample tick:
  - tick_cnt counts 0..CLK_DIV-1 and wraps; tick is asserted when tick_cnt == CLK_DIV-1.
  - On tick, each active voice does phase += KEY_INC[key_idx] >> octave_i. The add wraps mod 2^PHASE_W.
  - octave_i and mode_i are sampled only on tick.
- Shaping: p = phase[PHASE_W-1 -: SAMPLE_W].
  - saw = p.
  - square = all-ones if p MSB is 1, else 0.
  - triangle = (p << 1) if MSB is 0, else ~(p << 1), truncated to SAMPLE_W.
  - inverted saw = ~p.
  - Inactive voices contribute 0.
- Mix: sum of all voice outputs at width SAMPLE_W + log2(NUM_VOICES), then shifted right by log2(NUM_VOICES). Fixed scaling, no clipping, no saturation.

## Timing
- Reset values:
  - All outputs 0.
  - keys_q, pending, tick_cnt, every phase, age, key_idx and active are 0.
- Key press to voice_active_o: 2 cycles. Cycle 1 the edge is captured into pending; cycle 2 the voice is allocated and registered.
- N simultaneous presses take N further cycles to allocate. They are allocated in ascending key order.
- Release to voice inactive: 1 cycle after keys_i falls.
- Press and release of the same key inside one cycle window: the key is never allocated.
- Phase update is registered on the tick edge. sample_o and sample_valid_o are registered one cycle later, so each sample_valid_o pulse is followed by CLK_DIV-1 low cycles.
- Allocation coinciding with tick: allocation wins, the phase becomes 0 and is not incremented that tick.
- Reset mid-note clears everything, and the next tick is CLK_DIV cycles after reset deasserts.

## Structure
- Package synth_pkg holds:
  - wave_t enum {WAVE_SAW, WAVE_SQUARE, WAVE_TRI, WAVE_INV_SAW};
  - localparam table KEY_INC[0:12] of PHASE_W-bit increments, semitone-spaced, with KEY_INC[0] = 16'h0400;
  - function shape(p, wave_t).
- Sub-module voice_allocator contains pending, age, key_idx, active and steal logic.
- The top level holds tick_cnt, the phase accumulators, shaping and the mixer.

## Test plan
All scenarios use default parameters.
- Reset, idle for 1024 cycles:
  - sample_valid_o pulses every 256 cycles;
  - sample_o = 0 and voice_active_o = 4'b0000 throughout.
- Press key 0, mode 0, octave 0:
  - voice_active_o = 4'b0001 two cycles later;
  - after the first tick, sample_o = 8'h01 (phase 0x0400, p = 0x04, shifted >> 2).
- Same stimulus with octave_i = 1:
  - the phase advances 0x0200 per tick;
  - sample_o reaches 8'h01 on the second tick.
- Press keys 0–4 in the same cycle:
  - voices fill as 4'b0001, 4'b0011, 4'b0111, 4'b1111 over 4 cycles;
  - key 4 then steals voice 0 with one steal_o pulse.
- Mode 1 with key 0 held for 32 ticks:
  - sample_o = 8'h00 while phase < 0x8000;
  - sample_o = 8'h3F once the phase MSB is set.
- Release key 0 in the same cycle as a tick:
  - voice 0 is inactive on the next cycle;
  - the next sample_o excludes it;
  - pressing key 0 again restarts the phase at 0.
